// File: rtl/ascon_pkg.sv
// Shared constants, types and helpers for the ASCON substitution front-end.
package ascon_pkg;

    localparam int STATE_W = 320;
    localparam int LANE_W  = 64;
    localparam int NLANES  = 5;

    // Bit position inside a 64-bit lane (one S-box column).
    typedef logic [5:0] lane_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } eng_state_t;

    // Round constant for round index i, XORed into x2[7:0].
    function automatic logic [7:0] rc(input logic [3:0] i);
        return {~i, i};
    endfunction

    // Reference S-box table, index = {x0,x1,x2,x3,x4} column bits.
    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

endpackage

// File: rtl/ascon_pc_ps_engine_sbox.sv
// Shared 5-bit ASCON S-box cell (bitsliced form); in[4] / out[4] carry x0.
module ASCON (
    input  logic [4:0] in,
    output logic [4:0] out
);

    logic a0, a1, a2, a3, a4;
    logic b0, b1, b2, b3, b4;

    // Bitsliced chi-like substitution with the ASCON input/output affine layers.
    always_comb begin
        a0 = in[4] ^ in[0];
        a1 = in[3];
        a2 = in[2] ^ in[3];
        a3 = in[1];
        a4 = in[0] ^ in[1];

        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        out[3] = b1 ^ b0;
        out[4] = b0 ^ b4;
        out[1] = b3 ^ b2;
        out[2] = ~b2;
        out[0] = b4;
    end

endmodule

// File: rtl/ascon_pc_ps_engine.sv
// ASCON round front-end: constant addition then column-serial substitution,
// COLS S-box columns per cycle, valid/ready on both sides.
module ascon_pc_ps_engine
    import ascon_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [3:0]         round_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int NGRP  = LANE_W / COLS;
    localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

    if (!(COLS == 1 || COLS == 2 || COLS == 4 || COLS == 8 ||
          COLS == 16 || COLS == 32 || COLS == 64)) begin : g_bad_cols
        $error("ascon_pc_ps_engine: COLS must be a power of two in 1..64");
    end

    eng_state_t state, state_nx;
    logic [CNT_W-1:0] cnt;

    // work[4] is x0 ... work[0] is x4, so a column's bit m sits in work[m].
    logic [NLANES-1:0][LANE_W-1:0] work, work_nx, load_val;
    logic [COLS-1:0][4:0]          sb_in, sb_out;
    logic [NLANES-1:0][COLS-1:0]   col_out;
    logic [LANE_W+COLS-1:0]        cat;
    logic                          accept;

    // The working register rotates right by COLS each RUN cycle, so the
    // current group is always in the low COLS bits and the substituted bits
    // re-enter at the top. After NGRP cycles every column is back in place.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign sb_in[c] = {work[4][c], work[3][c], work[2][c], work[1][c], work[0][c]};

        ASCON u_sbox (
            .in  (sb_in[c]),
            .out (sb_out[c])
        );

        for (genvar m = 0; m < NLANES; m++) begin : g_bit
            assign col_out[m][c] = sb_out[c][m];
        end
    end

    assign accept    = in_valid && in_ready;
    assign out_state = work;

    // Accepted state with the round constant folded into x2[7:0].
    always_comb begin
        load_val       = in_state;
        load_val[2][7:0] = load_val[2][7:0] ^ rc(round_idx);
    end

    // One RUN step: substitute the low group and rotate it to the top.
    always_comb begin
        work_nx = work;
        cat     = '0;
        for (int m = 0; m < NLANES; m++) begin
            cat        = {col_out[m], work[m]};
            work_nx[m] = cat[LANE_W+COLS-1:COLS];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid)        state_nx = ST_RUN;
            ST_RUN:  if (cnt == CNT_LAST) state_nx = ST_DONE;
            ST_DONE: if (out_ready)       state_nx = ST_IDLE;
            default:                      state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        busy      = (state == ST_RUN);
        out_valid = (state == ST_DONE);
    end

    // Working register and group counter; counter saturates at NGRP-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            cnt  <= '0;
        end else if (accept) begin
            work <= load_val;
            cnt  <= '0;
        end else if (state == ST_RUN) begin
            work <= work_nx;
            if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ascon_pc_ps_engine.sv
// Scoreboard bench: three engines (COLS = 8, 1, 64) share one input stream.
module tb_ascon_pc_ps_engine;
    import ascon_pkg::*;

    typedef struct {
        logic [319:0] st;
        int           acc;
    } exp_t;

    localparam logic [319:0] EXP_Z0 = {64'h00000000000000F0, 64'h00000000000000F0,
        64'hFFFFFFFFFFFFFF0F, 64'h00000000000000F0, 64'h0};
    localparam logic [319:0] EXP_ONES = {64'hFFFFFFFFFFFFFFFF, 64'h00000000000000F0,
        64'hFFFFFFFFFFFFFF0F, 64'hFFFFFFFFFFFFFF0F, 64'hFFFFFFFFFFFFFFFF};
    localparam logic [319:0] EXP_Z11 = {64'h000000000000004B, 64'h000000000000004B,
        64'hFFFFFFFFFFFFFFB4, 64'h000000000000004B, 64'h0};

    logic         clk = 1'b0;
    logic         rst, iv, or0, hand_use, b2b, fin;
    logic [319:0] st, hand_exp;
    logic [3:0]   ri;
    wire  [2:0]   in_ready, out_valid, busy, ordy;
    wire  [319:0] out_state [3];

    int   cyc = 0;
    int   tmo = 0;
    int   tmo_seen = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [3][$];
    logic prev_ov [3] = '{default: 1'b0};
    logic prev_hs [3] = '{default: 1'b0};
    logic [319:0] prev_st [3] = '{default: '0};
    int   last_acc [3] = '{default: -1};
    logic rst_d = 1'b0;
    logic fin_done = 1'b0;

    assign ordy = {1'b1, 1'b1, or0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CL = (g == 0) ? 8 : (g == 1) ? 1 : 64;
        ascon_pc_ps_engine #(.COLS(CL)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv),
            .in_ready  (in_ready[g]),
            .in_state  (st),
            .round_idx (ri),
            .out_valid (out_valid[g]),
            .out_ready (ordy[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    function automatic int ngrp(input int g);
        return (g == 0) ? 8 : (g == 1) ? 64 : 1;
    endfunction

    // Column-by-column reference: p_C then table lookup per column.
    function automatic logic [319:0] ref_ps(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v, o;
        for (int k = 0; k < 5; k++) begin
            x[k] = s[319-64*k -: 64];
            y[k] = '0;
        end
        x[2][7:0] = x[2][7:0] ^ {~r, r};
        for (int j = 0; j < 64; j++) begin
            v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
            o = SBOX[v];
            for (int k = 0; k < 5; k++) y[k][j] = o[4-k];
        end
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string nm, input int g, input logic [319:0] act, input logic [319:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s[dut%0d]: got %h want %h", nm, g, act, want);
        end
    endtask

    task automatic chkb(input string nm, input int g, input logic act, input logic want);
        chk(nm, g, 320'(act), 320'(want));
    endtask

    // Monitor: pushes expected results at each accept, pops at each output handshake.
    always @(negedge clk) begin
        if (tmo != tmo_seen) begin
            chk("wait_timeout", 0, 320'(tmo), 320'(tmo_seen));
            tmo_seen = tmo;
        end
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                sb[g].delete();
                prev_ov[g]  = 1'b0;
                prev_hs[g]  = 1'b0;
                last_acc[g] = -1;
            end else begin
                if (!b2b) last_acc[g] = -1;
                if (rst_d) begin
                    chkb("rst_in_ready", g, in_ready[g], 1'b1);
                    chkb("rst_out_valid", g, out_valid[g], 1'b0);
                    chkb("rst_busy", g, busy[g], 1'b0);
                    chk("rst_out_state", g, out_state[g], '0);
                end else if (prev_hs[g]) begin
                    chkb("post_hs_out_valid", g, out_valid[g], 1'b0);
                    chkb("post_hs_in_ready", g, in_ready[g], 1'b1);
                    chk("post_hs_state_hold", g, out_state[g], prev_st[g]);
                end else if (prev_ov[g]) begin
                    chkb("done_out_valid_held", g, out_valid[g], 1'b1);
                    chk("done_state_stable", g, out_state[g], prev_st[g]);
                end
                chkb("flags_onehot", g, $onehot({in_ready[g], busy[g], out_valid[g]}), 1'b1);
                if (out_valid[g] && !prev_ov[g]) begin
                    if (sb[g].size() == 0) chkb("spurious_out_valid", g, 1'b1, 1'b0);
                    else chk("latency", g, 320'(cyc - sb[g][0].acc), 320'(ngrp(g)));
                end
                if (out_valid[g] && ordy[g] && sb[g].size() > 0) begin
                    chk("result", g, out_state[g], sb[g][0].st);
                    void'(sb[g].pop_front());
                end
                if (iv && in_ready[g]) begin
                    sb[g].push_back('{st: hand_use ? hand_exp : ref_ps(st, ri), acc: cyc + 1});
                    if (b2b && last_acc[g] >= 0)
                        chk("b2b_spacing", g, 320'(cyc + 1 - last_acc[g]), 320'(ngrp(g) + 2));
                    if (b2b) last_acc[g] = cyc + 1;
                end
                prev_ov[g] = out_valid[g];
                prev_hs[g] = out_valid[g] && ordy[g];
                prev_st[g] = out_state[g];
            end
        end
        rst_d = rst;
        if (fin && !fin_done) begin
            for (int g = 0; g < 3; g++) chk("drained", g, 320'(sb[g].size()), '0);
            fin_done = 1'b1;
        end
    end

    task automatic send(input logic [319:0] s, input logic [3:0] r, input logic hu, input logic [319:0] he);
        int n;
        @(posedge clk); #1;
        st = s; ri = r; hand_use = hu; hand_exp = he; iv = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready[0] && n < 200) begin @(negedge clk); n++; end
        if (!in_ready[0]) tmo++;
        @(posedge clk); #1;
        iv = 1'b0; hand_use = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(&in_ready) && n < 500) begin @(negedge clk); n++; end
        if (!(&in_ready)) tmo++;
    endtask

    task automatic wait_ov0();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid[0] && n < 200) begin @(negedge clk); n++; end
        if (!out_valid[0]) tmo++;
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; or0 = 1'b1; hand_use = 1'b0; b2b = 1'b0; fin = 1'b0;
        st = '0; ri = '0; hand_exp = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Hand-computed vectors.
        send('0, 4'd0, 1'b1, EXP_Z0);           wait_idle();
        send({320{1'b1}}, 4'd0, 1'b1, EXP_ONES); wait_idle();
        send('0, 4'd11, 1'b1, EXP_Z11);         wait_idle();

        // Every round index with a random state.
        for (int r = 0; r < 16; r++) begin
            send(rand320(), 4'(r), 1'b0, '0);
            wait_idle();
        end

        // Hold the result in DONE for 20 cycles while poking in_valid.
        @(posedge clk); #1 or0 = 1'b0;
        send(rand320(), 4'd5, 1'b0, '0);
        wait_ov0();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            iv = i[0];
            st = rand320();
            ri = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        iv = 1'b0; or0 = 1'b1;
        wait_idle();

        // Reset on the third RUN cycle, then repeat the all-zero vector.
        send(rand320(), 4'd3, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        send('0, 4'd0, 1'b1, EXP_Z0);
        wait_idle();

        // Back-to-back: in_valid held high, new data after each accept.
        @(posedge clk); #1;
        b2b = 1'b1; iv = 1'b1; st = rand320(); ri = 4'd9;
        for (int n = 0; n < 5; n++) begin
            int w;
            w = 0;
            @(negedge clk);
            while (!in_ready[0] && w < 200) begin @(negedge clk); w++; end
            if (!in_ready[0]) tmo++;
            @(posedge clk); #1;
            st = rand320();
            ri = 4'(n + 12);
        end
        iv = 1'b0; b2b = 1'b0;
        wait_idle();

        @(posedge clk); #1 fin = 1'b1;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
